// File: rtl/ae_mem_pkg.sv
// Shared definitions for the weight-stream memory: FSM state encoding and
// width helpers for row addresses and burst lengths.
package ae_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } wsm_state_t;

  function automatic int row_addr_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int row_len_w(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output FIFO with registered storage; holds head data stable while
// the consumer stalls. The producer must never push when count is 2.
module stream_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] ent_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push;
  logic         pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = ent_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        ent_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/weight_stream_memory.sv
// Row-organised weight store streaming bursts of rows over a valid/ready port,
// with a runtime write port for reloading weights.
module weight_stream_memory
  import ae_mem_pkg::*;
#(
  parameter int WEIGHT_NUM = 96,
  parameter int WEIGHT_W   = 8,
  parameter int LANES      = 4,
  parameter     INIT_FILE  = "",
  localparam int ROWS = WEIGHT_NUM / LANES,
  localparam int AW   = row_addr_w(ROWS),
  localparam int LW   = row_len_w(ROWS),
  localparam int DW   = LANES * WEIGHT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output wsm_state_t    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and payload holds while stalled.

  logic [DW-1:0] mem [ROWS];
  wsm_state_t    state_q, state_d;
  logic [AW-1:0] rd_addr_q, start_addr;
  logic [LW-1:0] rd_left_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_vld_q, rd_last_q;
  logic [1:0]    buf_count;
  logic          buf_valid;
  logic [DW:0]   buf_data;
  logic [2:0]    occupancy;
  logic          accept, issue, pop, drain_done;

  initial begin
    for (int i = 0; i < ROWS; i++) mem[i] = '0;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign accept    = req_valid && req_ready;
  assign pop       = buf_valid && out_ready;

  always_comb begin
    start_addr = req_addr;
    if (32'(req_addr) >= ROWS) start_addr = req_addr - AW'(ROWS);
  end

  // Occupancy counts the in-flight read so the buffer can never overflow.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    occupancy  = {1'b0, buf_count} + {2'b00, rd_vld_q} - {2'b00, pop};
    drain_done = !rd_vld_q && ((buf_count == 2'd0) || (buf_count == 2'd1 && pop));
    case (state_q)
      ST_IDLE: begin
        if (accept && req_len != '0) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        issue = (occupancy < 3'd2);
        if (issue && rd_left_q == LW'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      rd_left_q <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      if (accept) begin
        rd_addr_q <= start_addr;
        rd_left_q <= req_len;
      end else if (issue) begin
        rd_addr_q <= (rd_addr_q == AW'(ROWS - 1)) ? '0 : rd_addr_q + AW'(1);
        rd_left_q <= rd_left_q - LW'(1);
      end
      if (issue) rd_data_q <= mem[rd_addr_q];
      rd_vld_q  <= issue;
      rd_last_q <= issue && (rd_left_q == LW'(1));
    end
  end

  // Storage is deliberately outside reset; a same-edge read sees old data.
  always_ff @(posedge clk) begin
    if (wr_en && 32'(wr_addr) < ROWS) mem[wr_addr] <= wr_data;
  end

  stream_skid_buf #(.W(DW + 1)) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_vld_q),
    .in_data  ({rd_last_q, rd_data_q}),
    .out_valid(buf_valid),
    .out_ready(out_ready),
    .out_data (buf_data),
    .count    (buf_count)
  );

  assign out_valid = buf_valid;
  assign out_last  = buf_data[DW];
  assign out_data  = buf_data[DW-1:0];

endmodule

// File: tb/tb_weight_stream_memory.sv
// Bench for weight_stream_memory: preloads rows via the write port, then
// streams bursts and compares every delivered beat against a shadow model.
module tb_weight_stream_memory;
  import ae_mem_pkg::*;

  localparam int ROWS = 24;
  localparam int AW   = 5;
  localparam int LW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  wsm_state_t    dbg_state;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model [ROWS];
  int            n_checks = 0;
  int            n_fail = 0;
  int            beats_seen = 0;
  int            rdy_mode = 0;
  int            rdy_phase = 0;
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_beat = '0;

  weight_stream_memory #(
    .WEIGHT_NUM(96),
    .WEIGHT_W  (8),
    .LANES     (4),
    .INIT_FILE ("")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer back-pressure: 0 = always ready, 1 = 1,0,0 pattern, 2 = random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", 64'(out_valid), 64'(1));
        check_eq("stall_beat", 64'({out_last, out_data}), 64'(prev_beat));
      end
      if (out_valid && out_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          check_eq("beat", 64'({out_last, out_data}), 64'(e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_last, out_data};
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick(1);
    wr_en = 1'b0;
    if (a < ROWS) model[a] = d;
  endtask

  task automatic send_req(input int a, input int len);
    int start;
    int n;
    start = a % ROWS;
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), model[(start + i) % ROWS]});
    req_valid = 1'b1;
    req_addr  = AW'(a);
    req_len   = LW'(len);
    n = 0;
    while (!req_ready && n < 1000) begin
      tick(1);
      n++;
    end
    check_eq("req_ready_wait", 64'(req_ready), 64'(1));
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    check_eq("drain_left", 64'(exp_q.size()), 64'(0));
    check_eq("drain_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [7:0] b;
    int n;

    // Reset state
    tick(2);
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_out_last", 64'(out_last), 64'(0));
    check_eq("rst_out_data", 64'(out_data), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check_eq("rst_req_ready", 64'(req_ready), 64'(1));

    // Preload row r with r in every lane; an out-of-range write must be dropped
    for (int r = 0; r < ROWS; r++) begin
      b = 8'(r);
      write_row(r, {4{b}});
    end
    write_row(30, 32'hDEAD_BEEF);

    // Basic burst with exact latency and busy timing
    send_req(5, 3);
    @(negedge clk); check_eq("lat_c0_valid", 64'(out_valid), 64'(0));
    @(negedge clk); check_eq("lat_c1_valid", 64'(out_valid), 64'(0));
    @(negedge clk); check_eq("lat_c2_valid", 64'(out_valid), 64'(1));
    @(negedge clk);
    @(negedge clk);
    check_eq("c4_last", 64'(out_last), 64'(1));
    check_eq("c4_busy", 64'(busy), 64'(1));
    @(negedge clk);
    check_eq("c5_busy", 64'(busy), 64'(0));
    check_eq("c5_req_ready", 64'(req_ready), 64'(1));
    wait_done(100);

    // Wrap from last row back to row 0
    send_req(22, 4);
    wait_done(100);

    // Zero-length request produces nothing
    send_req(3, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("len0_busy", 64'(busy), 64'(0));
      check_eq("len0_req_ready", 64'(req_ready), 64'(1));
      check_eq("len0_out_valid", 64'(out_valid), 64'(0));
    end
    tick(1);

    // Back-pressure pattern 1,0,0
    rdy_phase = 0;
    rdy_mode  = 1;
    send_req(0, 6);
    wait_done(200);
    rdy_mode = 0;
    tick(1);

    // Read-before-write on row 10, then new data visible
    send_req(10, 1);
    write_row(10, 32'hAAAA_AAAA);
    wait_done(100);
    send_req(9, 3);
    wait_done(100);

    // Start address above ROWS-1 folds back into range
    send_req(29, 3);
    wait_done(100);

    // Random bursts under random back-pressure
    rdy_mode = 2;
    for (int k = 0; k < 4; k++) begin
      send_req($urandom_range(0, 23), $urandom_range(1, 24));
      wait_done(600);
    end
    rdy_mode = 0;
    tick(2);

    // Reset in the middle of an 8-row burst
    beats_seen = 0;
    send_req(0, 8);
    n = 0;
    while (beats_seen < 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("mid_two_beats", 64'(beats_seen), 64'(2));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'(0));
    check_eq("mid_rst_busy", 64'(busy), 64'(0));
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_eq("mid_req_ready", 64'(req_ready), 64'(1));
    beats_seen = 0;
    tick(20);
    check_eq("mid_no_beats", 64'(beats_seen), 64'(0));

    // Full sweep: contents survive reset and the dropped write
    send_req(0, 24);
    wait_done(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_stream_memory.md
WEIGHT_STREAM_MEMORY -- requirements
Module: weight_stream_memory

Interface
REQ-001 Parameter WEIGHT_NUM, default 96, total stored weights; SHALL be a multiple of LANES.
REQ-002 Parameter WEIGHT_W, default 8, bits per weight.
REQ-003 Parameter LANES, default 4, weights delivered per output beat; ROWS = WEIGHT_NUM/LANES, AW = max(1, clog2(ROWS)), LW = clog2(ROWS+1).
REQ-004 Parameter INIT_FILE, default "", binary-format preload file of ROWS words, lane 0 in LSBs; empty string means all-zero contents.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  in  1  burst request present.
REQ-008 req_ready  out  1  block accepts a request this cycle.
REQ-009 req_addr  in  AW  first row of burst.
REQ-010 req_len  in  LW  number of rows in burst, 0..ROWS.
REQ-011 wr_en  in  1  row write strobe (runtime weight reload).
REQ-012 wr_addr  in  AW  row written.
REQ-013 wr_data  in  LANES*WEIGHT_W  row data, lane 0 in LSBs.
REQ-014 out_valid  out  1  out_data holds a valid beat.
REQ-015 out_ready  in  1  consumer accepts beat.
REQ-016 out_data  out  LANES*WEIGHT_W  one row, lane 0 in LSBs.
REQ-017 out_last  out  1  current beat is final row of burst.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 Request SHALL be accepted on a cycle with req_valid && req_ready; req_ready SHALL be high only in IDLE.
REQ-020 FSM states IDLE, STREAM, DRAIN: IDLE->STREAM on accept with req_len>0; STREAM->DRAIN when last read issued; DRAIN->IDLE when output buffer empty and last beat transferred.
REQ-021 Accept with req_len=0 SHALL be consumed with no output beats and FSM remaining in IDLE.
REQ-022 Burst rows SHALL be req_addr, req_addr+1, ..., wrapping from ROWS-1 to 0; req_addr >= ROWS SHALL be reduced modulo ROWS.
REQ-023 Memory read SHALL be synchronous; first out_valid SHALL assert exactly 2 cycles after accept.
REQ-024 Beat transfers on out_valid && out_ready; with out_ready held high, one beat per cycle with no bubbles.
REQ-025 While out_valid && !out_ready, out_data, out_last and out_valid SHALL hold stable.
REQ-026 Reads SHALL be issued only when buffer space exists; a 2-entry output buffer SHALL absorb the in-flight read so no beat is lost or duplicated.
REQ-027 out_last SHALL be high only on the req_len-th beat.
REQ-028 Writes SHALL be accepted in any state, one row per cycle, taking effect at next edge.
REQ-029 Same-cycle read and write to one row SHALL return old data (read-before-write); later reads return new data.
REQ-030 wr_addr >= ROWS SHALL be ignored.

Reset
REQ-031 rst_n low SHALL force state IDLE, out_valid=0, out_last=0, out_data=0, busy=0, buffer empty, counters 0; req_ready=1 after release.
REQ-032 Reset mid-burst SHALL abort the burst; no remaining beats SHALL appear after release.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-034 FSM state enum and row-address/length width helper functions SHALL reside in shared package ae_mem_pkg.
REQ-035 Output buffer SHALL be sub-module stream_skid_buf (2-entry, parameterised width).

Verification (WEIGHT_NUM=96, LANES=4, ROWS=24, row r preloaded with value r in every lane)
REQ-036 req_addr=5, req_len=3, out_ready=1 -> beats rows 5,6,7 on cycles +2,+3,+4; out_last on row 7; busy drops following cycle.
REQ-037 req_addr=22, req_len=4 -> beats rows 22,23,0,1; out_last on row 1.
REQ-038 req_addr=0, req_len=6, out_ready toggling 1,0,0,1,... -> rows 0..5 delivered in order exactly once, out_data stable during stalls.
REQ-039 Write row 10 = 0xAA per lane in same cycle row 10 is read -> beat shows 0x0A per lane; next burst over row 10 shows 0xAA.
REQ-040 rst_n pulsed low after 2 of 8 beats -> out_valid 0 immediately, no further beats, req_ready=1 after release, row contents unchanged.
REQ-041 req_len=0 -> no beats, busy stays 0, req_ready stays 1.
